// File: rtl/scan_mux.sv
// scan_mux: registered NCH-to-1 multiplexer with enable, manual select
// and a dwell-timed round-robin auto scan.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   en      enable; 0 clears out/valid/wrap and freezes the scan
//   mode    0 = manual (sel), 1 = auto scan
//   data    NCH*W packed channels, channel k at [k*W +: W]
//   sel     manual channel select
//   out     registered selected channel data
//   out_sel channel index that produced out
//   valid   out holds a legal channel's data
//   wrap    one-cycle pulse on the first channel-0 output of a new pass
module scan_mux #(
    parameter  int NCH   = 8,
    parameter  int W     = 1,
    parameter  int DWELL = 1,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [NCH*W-1:0]  data,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out,
    output logic [SELW-1:0]   out_sel,
    output logic              valid,
    output logic              wrap
);

    localparam logic [SELW:0]   NCH_L   = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] CH_LAST = SELW'(NCH - 1);
    localparam logic [15:0]     DW_LAST = 16'(DWELL - 1);

    logic [W-1:0]    r_out;
    logic [SELW-1:0] r_out_sel;
    logic            r_valid;
    logic            r_wrap;
    logic [SELW-1:0] r_ch;
    logic [15:0]     r_dcnt;
    logic            r_pmode;

    logic [SELW-1:0] w_ch_eff;
    logic [15:0]     w_dcnt_eff;
    logic [W-1:0]    w_man_data;
    logic [W-1:0]    w_auto_data;
    logic            w_man_ok;
    logic            w_last_dw;
    logic            w_last_ch;
    logic            w_wrap_now;

    always_comb begin
        // Entering auto mode restarts the scan at channel 0, full dwell.
        w_ch_eff   = r_pmode ? r_ch   : '0;
        w_dcnt_eff = r_pmode ? r_dcnt : '0;
        w_man_ok   = {1'b0, sel} < NCH_L;
        w_last_dw  = (w_dcnt_eff == DW_LAST);
        w_last_ch  = (w_ch_eff == CH_LAST);
        // ch=0/dcnt=0 while already scanning only follows a wrap step.
        w_wrap_now = r_pmode && (r_ch == '0) && (r_dcnt == '0);
        w_man_data  = '0;
        w_auto_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k))
                w_man_data = data[k*W +: W];
            if (w_ch_eff == SELW'(k))
                w_auto_data = data[k*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out     <= '0;
            r_out_sel <= '0;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
            r_ch      <= '0;
            r_dcnt    <= '0;
            r_pmode   <= 1'b0;
        end else if (!en) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (!mode) begin
            r_pmode   <= 1'b0;
            r_out     <= w_man_ok ? w_man_data : '0;
            r_valid   <= w_man_ok;
            r_out_sel <= sel;
            r_wrap    <= 1'b0;
        end else begin
            r_pmode   <= 1'b1;
            r_out     <= w_auto_data;
            r_out_sel <= w_ch_eff;
            r_valid   <= 1'b1;
            r_wrap    <= w_wrap_now;
            if (w_last_dw) begin
                r_dcnt <= '0;
                r_ch   <= w_last_ch ? '0 : w_ch_eff + SELW'(1);
            end else begin
                r_dcnt <= w_dcnt_eff + 16'd1;
                r_ch   <= w_ch_eff;
            end
        end
    end

    assign out     = r_out;
    assign out_sel = r_out_sel;
    assign valid   = r_valid;
    assign wrap    = r_wrap;

endmodule
